am2901_mul_seq: RTL and testbench

- Microsequencer that drives one Am2901 4-bit slice through an unsigned 4x4 shift-and-add multiply.
- Sits between a requester (start/operands/done handshake) and the Am2901 control pins: i, a, b, d, cin, oe and the shift lines ram3/q3.
- Produces an 8-bit product by reading the high nibble from the accumulator register and the low nibble from Q.

---
 rtl/am2901_pkg.sv | 63 ++++++
 rtl/am2901_mul_seq.sv | 173 +++++++++++++++++
 tb/tb_am2901_mul_seq.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/am2901_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : am2901_pkg
//  Description : Shared Am2901 instruction-field encodings, the multiply
//                sequencer state type and a helper to pack instruction words.
//  Revision    : 1.0  initial release
// ============================================================================
package am2901_pkg;

    // Source operand select, instruction bits [2:0]: R,S pair fed to the ALU
    localparam logic [2:0] SRC_AQ = 3'd0;  // R=A, S=Q
    localparam logic [2:0] SRC_AB = 3'd1;  // R=A, S=B
    localparam logic [2:0] SRC_ZQ = 3'd2;  // R=0, S=Q
    localparam logic [2:0] SRC_ZB = 3'd3;  // R=0, S=B
    localparam logic [2:0] SRC_ZA = 3'd4;  // R=0, S=A
    localparam logic [2:0] SRC_DA = 3'd5;  // R=D, S=A
    localparam logic [2:0] SRC_DQ = 3'd6;  // R=D, S=Q
    localparam logic [2:0] SRC_DZ = 3'd7;  // R=D, S=0

    // ALU function, instruction bits [5:3]
    localparam logic [2:0] FN_ADD   = 3'd0;  // R + S
    localparam logic [2:0] FN_SUBR  = 3'd1;  // S - R
    localparam logic [2:0] FN_SUBS  = 3'd2;  // R - S
    localparam logic [2:0] FN_OR    = 3'd3;  // R | S
    localparam logic [2:0] FN_AND   = 3'd4;  // R & S
    localparam logic [2:0] FN_NOTRS = 3'd5;  // ~R & S
    localparam logic [2:0] FN_EXOR  = 3'd6;  // R ^ S
    localparam logic [2:0] FN_EXNOR = 3'd7;  // ~(R ^ S)

    // Destination control, instruction bits [8:6]
    localparam logic [2:0] DST_QREG  = 3'd0;  // F -> Q
    localparam logic [2:0] DST_NOP   = 3'd1;  // no write, Y = F
    localparam logic [2:0] DST_RAMA  = 3'd2;  // F -> B, Y = A
    localparam logic [2:0] DST_RAMF  = 3'd3;  // F -> B, Y = F
    localparam logic [2:0] DST_RAMQD = 3'd4;  // F/2 -> B, Q/2 -> Q
    localparam logic [2:0] DST_RAMD  = 3'd5;  // F/2 -> B
    localparam logic [2:0] DST_RAMQU = 3'd6;  // 2F -> B, 2Q -> Q
    localparam logic [2:0] DST_RAMU  = 3'd7;  // 2F -> B

    // Idle instruction: NOP destination, OR, ZA -- touches no register
    localparam logic [8:0] NOP_INSTR = 9'o134;

    // Multiply sequencer states
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LDM  = 3'd1,
        ST_LDQ  = 3'd2,
        ST_CLR  = 3'd3,
        ST_MUL  = 3'd4,
        ST_RDH  = 3'd5,
        ST_RDL  = 3'd6,
        ST_DONE = 3'd7
    } seq_state_e;

    // Pack the three fields into an Am2901 instruction word {dest, func, src}
    function automatic logic [8:0] mk_instr(input logic [2:0] dst,
                                            input logic [2:0] fn,
                                            input logic [2:0] src);
        return {dst, fn, src};
    endfunction

endpackage
`default_nettype wire

// File: rtl/am2901_mul_seq.sv
`default_nettype none
// ============================================================================
//  Module      : am2901_mul_seq
//  Description : Microsequencer steering one Am2901 4-bit slice through an
//                unsigned 4x4 shift-and-add multiply. The high product nibble
//                is read from the accumulator register, the low from Q.
//  Revision    : 1.0  initial release
// ============================================================================
module am2901_mul_seq
    import am2901_pkg::*;
#(
    parameter logic [3:0] ACC_REG   = 4'd0,
    parameter logic [3:0] MCAND_REG = 4'd1,
    parameter int         N_ITER    = 4
) (
    input  logic       cp,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] mcand,
    input  logic [3:0] mplier,
    output logic       busy,
    output logic       done,
    output logic [7:0] product,
    output logic [8:0] i,
    output logic [3:0] a,
    output logic [3:0] b,
    output logic [3:0] d,
    output logic       cin,
    output logic       oe,
    output logic       ram3_drv,
    output logic       q3_drv,
    output logic       shift_en,
    input  logic       cout,
    input  logic       ram0,
    input  logic       q0,
    input  logic [3:0] y
);

    localparam int CNT_W = (N_ITER > 1) ? $clog2(N_ITER) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_ITER - 1);

    seq_state_e       state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [3:0]       mcand_q,  mcand_d;
    logic [3:0]       mplier_q, mplier_d;
    logic [7:0]       product_q, product_d;

    // State, iteration counter, operand latches and product register
    always_ff @(posedge cp) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            mcand_q   <= 4'd0;
            mplier_q  <= 4'd0;
            product_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            product_q <= product_d;
        end
    end

    // Next-state, counter, operand capture and product nibble capture
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        product_d = product_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // Operands are frozen here; input changes while busy are ignored
                    mcand_d  = mcand;
                    mplier_d = mplier;
                    state_d  = ST_LDM;
                end
            end
            ST_LDM: state_d = ST_LDQ;
            ST_LDQ: state_d = ST_CLR;
            ST_CLR: state_d = ST_MUL;
            ST_MUL: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_RDH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RDH: begin
                product_d = {y, product_q[3:0]};
                state_d   = ST_RDL;
            end
            ST_RDL: begin
                product_d = {product_q[7:4], y};
                state_d   = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Am2901 control pins and handshake outputs decoded from the current state
    always_comb begin
        i        = NOP_INSTR;
        a        = 4'd0;
        b        = 4'd0;
        d        = 4'd0;
        cin      = 1'b0;
        oe       = 1'b1;
        shift_en = 1'b0;
        ram3_drv = 1'b0;
        q3_drv   = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state_q)
            ST_IDLE: ;
            ST_LDM: begin
                // RAM[MCAND_REG] <= D + 0
                i    = mk_instr(DST_RAMF, FN_ADD, SRC_DZ);
                d    = mcand_q;
                b    = MCAND_REG;
                busy = 1'b1;
            end
            ST_LDQ: begin
                // Q <= D + 0; multiplier bits are consumed from Q's LSB
                i    = mk_instr(DST_QREG, FN_ADD, SRC_DZ);
                d    = mplier_q;
                busy = 1'b1;
            end
            ST_CLR: begin
                // RAM[ACC] <= 0 & A
                i    = mk_instr(DST_RAMF, FN_AND, SRC_ZA);
                a    = ACC_REG;
                b    = ACC_REG;
                busy = 1'b1;
            end
            ST_MUL: begin
                // ACC + (q0 ? MCAND : 0), then shift {ACC,Q} right one place.
                // The ALU carry re-enters at the top of ACC so 15x15 keeps bit 7,
                // and the bit falling out of ACC moves into the top of Q.
                i        = mk_instr(DST_RAMQD, FN_ADD, q0 ? SRC_AB : SRC_ZB);
                a        = MCAND_REG;
                b        = ACC_REG;
                shift_en = 1'b1;
                ram3_drv = cout;
                q3_drv   = ram0;
                busy     = 1'b1;
            end
            ST_RDH: begin
                // Y = ACC, high product nibble
                i    = mk_instr(DST_NOP, FN_OR, SRC_ZA);
                a    = ACC_REG;
                oe   = 1'b0;
                busy = 1'b1;
            end
            ST_RDL: begin
                // Y = Q, low product nibble
                i    = mk_instr(DST_NOP, FN_OR, SRC_ZQ);
                oe   = 1'b0;
                busy = 1'b1;
            end
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

    assign product = product_q;

endmodule
`default_nettype wire

// File: tb/tb_am2901_mul_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_am2901_mul_seq
//  Description : Bench for am2901_mul_seq driving a behavioural Am2901 slice.
//                A driver issues multiplies and queues expected products; a
//                monitor pops and compares whenever done pulses.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_am2901_mul_seq;

    logic       cp = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [3:0] mcand = 4'd0;
    logic [3:0] mplier = 4'd0;
    logic       busy, done, cin, oe, ram3_drv, q3_drv, shift_en;
    logic [7:0] product;
    logic [8:0] i;
    logic [3:0] a, b, d;
    logic       cout, ram0, q0;
    logic [3:0] y;

    am2901_mul_seq #(.ACC_REG(4'd0), .MCAND_REG(4'd1), .N_ITER(4)) dut (
        .cp(cp), .reset(reset), .start(start), .mcand(mcand), .mplier(mplier),
        .busy(busy), .done(done), .product(product), .i(i), .a(a), .b(b),
        .d(d), .cin(cin), .oe(oe), .ram3_drv(ram3_drv), .q3_drv(q3_drv),
        .shift_en(shift_en), .cout(cout), .ram0(ram0), .q0(q0), .y(y)
    );

    always #5 cp = ~cp;

    // ------------------------------------------------------------------
    // Behavioural Am2901 slice
    // ------------------------------------------------------------------
    logic [3:0] ram [16];
    logic [3:0] qreg;
    logic [3:0] r_op, s_op, f;
    logic [4:0] sum;
    logic       ram3_line, q3_line;

    // Shift lines: sequencer drives them only while shift_en, otherwise pulled low
    assign ram3_line = shift_en ? ram3_drv : 1'b0;
    assign q3_line   = shift_en ? q3_drv   : 1'b0;

    always_comb begin
        r_op = 4'd0;
        s_op = 4'd0;
        sum  = 5'd0;
        f    = 4'd0;
        cout = 1'b0;
        case (i[2:0])
            3'd0: begin r_op = ram[a]; s_op = qreg;   end
            3'd1: begin r_op = ram[a]; s_op = ram[b]; end
            3'd2: begin r_op = 4'd0;   s_op = qreg;   end
            3'd3: begin r_op = 4'd0;   s_op = ram[b]; end
            3'd4: begin r_op = 4'd0;   s_op = ram[a]; end
            3'd5: begin r_op = d;      s_op = ram[a]; end
            3'd6: begin r_op = d;      s_op = qreg;   end
            default: begin r_op = d;   s_op = 4'd0;   end
        endcase
        case (i[5:3])
            3'd0: begin sum = {1'b0, r_op} + {1'b0, s_op} + {4'd0, cin}; f = sum[3:0]; cout = sum[4]; end
            3'd1: begin sum = {1'b0, s_op} + {1'b0, ~r_op} + {4'd0, cin}; f = sum[3:0]; cout = sum[4]; end
            3'd2: begin sum = {1'b0, r_op} + {1'b0, ~s_op} + {4'd0, cin}; f = sum[3:0]; cout = sum[4]; end
            3'd3: f = r_op | s_op;
            3'd4: f = r_op & s_op;
            3'd5: f = ~r_op & s_op;
            3'd6: f = r_op ^ s_op;
            default: f = ~(r_op ^ s_op);
        endcase
    end

    assign ram0 = f[0];
    assign q0   = qreg[0];
    assign y    = oe ? 4'd0 : ((i[8:6] == 3'd2) ? ram[a] : f);

    always @(posedge cp) begin
        case (i[8:6])
            3'd0: qreg <= f;
            3'd2, 3'd3: ram[b] <= f;
            3'd4: begin ram[b] <= {ram3_line, f[3:1]}; qreg <= {q3_line, qreg[3:1]}; end
            3'd5: ram[b] <= {ram3_line, f[3:1]};
            3'd6: begin ram[b] <= {f[2:0], 1'b0}; qreg <= {qreg[2:0], 1'b0}; end
            3'd7: ram[b] <= {f[2:0], 1'b0};
            default: ;
        endcase
    end

    initial begin
        for (int k = 0; k < 16; k++) ram[k] = 4'd0;
        qreg = 4'd0;
    end

    // ------------------------------------------------------------------
    // Scoreboard bookkeeping
    // ------------------------------------------------------------------
    typedef struct {
        logic [7:0] prod;
        int         acc_cyc;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   busy_cnt = 0;
    bit   seen_ram3 = 1'b0;

    always @(posedge cp) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding request
    initial begin
        exp_t e;
        forever begin
            @(negedge cp);
            if (reset) busy_cnt = 0;
            else if (busy) busy_cnt++;
            if (shift_en && ram3_drv) seen_ram3 = 1'b1;
            if (done) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    chk("product", int'(product), int'(e.prod));
                    chk("latency", cyc - e.acc_cyc, 9);
                    chk("busy_cycles", busy_cnt, 9);
                end
                busy_cnt = 0;
            end
        end
    end

    // Present operands with start for one edge; queue the expectation if asked
    task automatic issue(input logic [3:0] mc, input logic [3:0] mp,
                         input bit push, input logic [7:0] exp_p);
        exp_t e;
        @(negedge cp);
        mcand  = mc;
        mplier = mp;
        start  = 1'b1;
        @(posedge cp);
        #1;
        start = 1'b0;
        if (push) begin
            e.prod    = exp_p;
            e.acc_cyc = cyc;
            sb_q.push_back(e);
        end
    endtask

    // Bounded wait for the done pulse
    task automatic wait_done();
        int n = 0;
        do begin
            @(negedge cp);
            n++;
        end while (!done && n < 40);
        if (!done) chk("done_timeout", 0, 1);
    endtask

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    initial begin
        exp_t e;
        repeat (3) @(negedge cp);
        // Reset values
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_product", product, 0);
        chk("rst_i", i, 9'o134);
        chk("rst_abd", {a, b, d}, 0);
        chk("rst_cin", cin, 0);
        chk("rst_oe", oe, 1);
        chk("rst_shift_en", shift_en, 0);
        chk("rst_shiftdrv", {ram3_drv, q3_drv}, 0);
        reset = 1'b0;

        issue(4'd3, 4'd5, 1'b1, 8'h0F);
        wait_done();

        seen_ram3 = 1'b0;
        issue(4'd15, 4'd15, 1'b1, 8'hE1);
        wait_done();
        chk("ram3_carry_seen", seen_ram3, 1);

        issue(4'd0, 4'd9, 1'b1, 8'h00);
        wait_done();
        issue(4'd9, 4'd0, 1'b1, 8'h00);
        wait_done();
        issue(4'd9, 4'd1, 1'b1, 8'h09);
        wait_done();

        // start held high; operands scrambled while busy; re-accept after DONE
        @(negedge cp);
        mcand  = 4'd6;
        mplier = 4'd7;
        start  = 1'b1;
        @(posedge cp);
        #1;
        e.prod = 8'h2A; e.acc_cyc = cyc; sb_q.push_back(e);
        for (int k = 1; k <= 10; k++) begin
            @(negedge cp);
            mcand  = 4'(k);
            mplier = 4'(15 - k);
        end
        @(negedge cp);
        mcand  = 4'd4;
        mplier = 4'd5;
        @(posedge cp);
        #1;
        start = 1'b0;
        e.prod = 8'h14; e.acc_cyc = cyc; sb_q.push_back(e);
        wait_done();

        // Abort in the second MUL cycle
        issue(4'd5, 4'd5, 1'b0, 8'h00);
        repeat (5) @(negedge cp);
        chk("abort_in_mul", shift_en, 1);
        reset = 1'b1;
        @(negedge cp);
        chk("abort_busy", busy, 0);
        chk("abort_product", product, 0);
        chk("abort_i", i, 9'o134);
        chk("abort_oe", oe, 1);
        reset = 1'b0;
        issue(4'd2, 4'd3, 1'b1, 8'h06);
        wait_done();

        // Full operand sweep
        for (int mc = 0; mc < 16; mc++) begin
            for (int mp = 0; mp < 16; mp++) begin
                issue(4'(mc), 4'(mp), 1'b1, 8'(mc * mp));
                wait_done();
            end
        end

        repeat (3) @(negedge cp);
        chk("sb_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
